// File: rtl/udp_framer_pkg.sv
// Shared types and constants for the UDP transmit framer.
package udp_framer_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_HDR   = 2'd1,
    ST_SEQ   = 2'd2,
    ST_DRAIN = 2'd3
  } framer_state_e;

  localparam int UDP_HDR_BYTES = 8;
  localparam int SEQ_BYTES     = 4;

  // Width needed to hold values 0..max_val inclusive.
  function automatic int count_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/framer_byte_ram.sv
// Simple dual-port byte buffer with one-cycle registered read.
module framer_byte_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; output holds while rd_en is low.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_tx_framer.sv
// Buffers a byte stream and emits it as UDP datagrams: header, optional
// 32-bit sequence prefix, then the buffered payload.
module udp_tx_framer
  import udp_framer_pkg::*;
#(
  parameter int MAX_PAYLOAD  = 1024,
  parameter int SEQ_ENABLE   = 1,
  parameter int IDLE_TIMEOUT = 1250,
  parameter int IP_TTL       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic [31:0] cfg_source_ip,
  input  logic [31:0] cfg_dest_ip,
  input  logic [15:0] cfg_source_port,
  input  logic [15:0] cfg_dest_port,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [5:0]  m_udp_ip_dscp,
  output logic [1:0]  m_udp_ip_ecn,
  output logic [7:0]  m_udp_ip_ttl,
  output logic [31:0] m_udp_ip_source_ip,
  output logic [31:0] m_udp_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [15:0] m_udp_checksum,
  output logic [7:0]  m_udp_payload_axis_tdata,
  output logic        m_udp_payload_axis_tvalid,
  input  logic        m_udp_payload_axis_tready,
  output logic        m_udp_payload_axis_tlast,
  output logic        m_udp_payload_axis_tuser,
  output logic        datagram_sent,
  output logic [31:0] seq_num
);

  localparam int CW = count_width(MAX_PAYLOAD);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int IW = count_width(IDLE_TIMEOUT);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_PAYLOAD);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
  localparam logic [15:0]   LEN_BASE  =
    16'(UDP_HDR_BYTES + ((SEQ_ENABLE != 0) ? SEQ_BYTES : 0));

  framer_state_e state_q, state_d;

  logic [CW-1:0] count_q;
  logic [IW-1:0] idle_q;
  logic [31:0]   seq_q;
  logic [1:0]    seq_idx_q;

  // Payload read pipeline: p0 is the read address, p1 the RAM output.
  logic [CW-1:0] rd_ptr_p0;
  logic [7:0]    ram_data_p1;
  logic          vld_p1;
  logic          last_p1;

  logic [7:0]  ttl_q;
  logic [31:0] src_ip_q, dst_ip_q;
  logic [15:0] src_port_q, dst_port_q, len_q;

  logic          fill_accept, idle_hit, close;
  logic [CW-1:0] count_inc;
  logic          seq_hs, seq_done, drain_done;
  logic          pf_en, pf_hit;

  // Sequence number bytes go out most significant first.
  function automatic logic [7:0] seq_byte(input logic [31:0] s, input logic [1:0] idx);
    case (idx)
      2'd0:    return s[31:24];
      2'd1:    return s[23:16];
      2'd2:    return s[15:8];
      default: return s[7:0];
    endcase
  endfunction

  assign count_inc   = count_q + CW'(1);
  assign fill_accept = (state_q == ST_FILL) && s_axis_tvalid && !rst;
  assign idle_hit    = (IDLE_TIMEOUT != 0) && (count_q != '0) && !fill_accept &&
                       (idle_q == IDLE_LAST);
  assign close       = (state_q == ST_FILL) &&
                       ((fill_accept && (s_axis_tlast || count_inc == MAX_CNT)) || idle_hit);
  assign seq_hs      = (state_q == ST_SEQ) && m_udp_payload_axis_tready;
  assign seq_done    = seq_hs && (seq_idx_q == 2'd3);
  assign drain_done  = (state_q == ST_DRAIN) && vld_p1 && last_p1 && m_udp_payload_axis_tready;
  // Prefetch the first byte during the header so DRAIN starts without a bubble.
  assign pf_en       = ((state_q == ST_HDR) && !vld_p1) ||
                       ((state_q == ST_DRAIN) && (!vld_p1 || m_udp_payload_axis_tready));
  assign pf_hit      = pf_en && (rd_ptr_p0 < count_q);

  framer_byte_ram #(
    .DEPTH  (MAX_PAYLOAD),
    .DATA_W (8)
  ) u_ram (
    .clk     (clk),
    .wr_en   (fill_accept),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (s_axis_tdata),
    .rd_en   (pf_hit),
    .rd_addr (rd_ptr_p0[AW-1:0]),
    .rd_data (ram_data_p1)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FILL;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs; everything idles low while in reset.
  always_comb begin
    state_d                   = state_q;
    s_axis_tready             = 1'b0;
    m_udp_hdr_valid           = 1'b0;
    m_udp_payload_axis_tvalid = 1'b0;
    m_udp_payload_axis_tdata  = ram_data_p1;
    m_udp_payload_axis_tlast  = 1'b0;
    datagram_sent             = 1'b0;
    case (state_q)
      ST_FILL: begin
        s_axis_tready = 1'b1;
        if (close) state_d = ST_HDR;
      end
      ST_HDR: begin
        m_udp_hdr_valid = 1'b1;
        if (m_udp_hdr_ready) state_d = (SEQ_ENABLE != 0) ? ST_SEQ : ST_DRAIN;
      end
      ST_SEQ: begin
        m_udp_payload_axis_tvalid = 1'b1;
        m_udp_payload_axis_tdata  = seq_byte(seq_q, seq_idx_q);
        if (seq_done) state_d = ST_DRAIN;
      end
      default: begin
        m_udp_payload_axis_tvalid = vld_p1;
        m_udp_payload_axis_tlast  = vld_p1 && last_p1;
        datagram_sent             = drain_done;
        if (drain_done) state_d = ST_FILL;
      end
    endcase
    if (rst) begin
      s_axis_tready             = 1'b0;
      m_udp_hdr_valid           = 1'b0;
      m_udp_payload_axis_tvalid = 1'b0;
      m_udp_payload_axis_tlast  = 1'b0;
      datagram_sent             = 1'b0;
    end
  end

  // Fill count, idle timer, sequence counter and payload read pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      idle_q    <= '0;
      seq_q     <= '0;
      seq_idx_q <= '0;
      rd_ptr_p0 <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
    end else begin
      if (fill_accept)     count_q <= count_inc;
      else if (drain_done) count_q <= '0;

      if (close || fill_accept || state_q != ST_FILL || count_q == '0 || IDLE_TIMEOUT == 0)
        idle_q <= '0;
      else
        idle_q <= idle_q + IW'(1);

      if (seq_hs)     seq_idx_q <= seq_idx_q + 2'd1;
      if (drain_done) seq_q     <= seq_q + 32'd1;

      // ---- p0 -> p1: buffer read ----
      if (pf_en) begin
        vld_p1 <= pf_hit;
        if (pf_hit) begin
          rd_ptr_p0 <= rd_ptr_p0 + CW'(1);
          last_p1   <= (rd_ptr_p0 + CW'(1) == count_q);
        end
      end
      if (drain_done) rd_ptr_p0 <= '0;
    end
  end

  // Header fields are captured once, when the datagram closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ttl_q      <= '0;
      src_ip_q   <= '0;
      dst_ip_q   <= '0;
      src_port_q <= '0;
      dst_port_q <= '0;
      len_q      <= '0;
    end else if (close) begin
      ttl_q      <= 8'(IP_TTL);
      src_ip_q   <= cfg_source_ip;
      dst_ip_q   <= cfg_dest_ip;
      src_port_q <= cfg_source_port;
      dst_port_q <= cfg_dest_port;
      len_q      <= LEN_BASE + 16'(fill_accept ? count_inc : count_q);
    end
  end

  assign m_udp_ip_dscp            = '0;
  assign m_udp_ip_ecn             = '0;
  assign m_udp_checksum           = '0;
  assign m_udp_payload_axis_tuser = 1'b0;
  assign m_udp_ip_ttl             = ttl_q;
  assign m_udp_ip_source_ip       = src_ip_q;
  assign m_udp_ip_dest_ip         = dst_ip_q;
  assign m_udp_source_port        = src_port_q;
  assign m_udp_dest_port          = dst_port_q;
  assign m_udp_length             = len_q;
  assign seq_num                  = seq_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed bench for udp_tx_framer: one DUT with sequence prefix, one without.
module tb_udp_tx_framer;
  localparam int MAXP = 16;
  localparam int IDLE = 20;

  logic clk = 1'b0;
  always #4 clk = ~clk;
  logic rst = 1'b1;

  logic [31:0] cfg_sip = 32'h0A00_0001, cfg_dip = 32'h0A00_0002;
  logic [15:0] cfg_sport = 16'd4000, cfg_dport = 16'd1234;

  // DUT with sequence prefix
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic        hdr_valid, hdr_ready = 1'b1;
  logic [5:0]  dscp;
  logic [1:0]  ecn;
  logic [7:0]  ttl;
  logic [31:0] sip, dip, seq_num;
  logic [15:0] sport, dport, ulen, csum;
  logic [7:0]  p_tdata;
  logic        p_tvalid, p_tready = 1'b1, p_tlast, p_tuser, sent;

  // DUT without sequence prefix
  logic [7:0]  z_tdata = '0;
  logic        z_tvalid = 1'b0, z_tlast = 1'b0, z_tready;
  logic        z_hdr_valid, z_hdr_ready = 1'b1;
  logic [5:0]  z_dscp;
  logic [1:0]  z_ecn;
  logic [7:0]  z_ttl;
  logic [31:0] z_sip, z_dip, z_seq_num;
  logic [15:0] z_sport, z_dport, z_ulen, z_csum;
  logic [7:0]  z_pdata;
  logic        z_pvalid, z_pready = 1'b1, z_plast, z_puser, z_sent;

  udp_tx_framer #(.MAX_PAYLOAD(MAXP), .SEQ_ENABLE(1), .IDLE_TIMEOUT(IDLE), .IP_TTL(64)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .cfg_source_ip(cfg_sip), .cfg_dest_ip(cfg_dip), .cfg_source_port(cfg_sport), .cfg_dest_port(cfg_dport),
    .m_udp_hdr_valid(hdr_valid), .m_udp_hdr_ready(hdr_ready),
    .m_udp_ip_dscp(dscp), .m_udp_ip_ecn(ecn), .m_udp_ip_ttl(ttl),
    .m_udp_ip_source_ip(sip), .m_udp_ip_dest_ip(dip),
    .m_udp_source_port(sport), .m_udp_dest_port(dport),
    .m_udp_length(ulen), .m_udp_checksum(csum),
    .m_udp_payload_axis_tdata(p_tdata), .m_udp_payload_axis_tvalid(p_tvalid),
    .m_udp_payload_axis_tready(p_tready), .m_udp_payload_axis_tlast(p_tlast),
    .m_udp_payload_axis_tuser(p_tuser), .datagram_sent(sent), .seq_num(seq_num)
  );

  udp_tx_framer #(.MAX_PAYLOAD(MAXP), .SEQ_ENABLE(0), .IDLE_TIMEOUT(IDLE), .IP_TTL(64)) dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(z_tdata), .s_axis_tvalid(z_tvalid), .s_axis_tready(z_tready), .s_axis_tlast(z_tlast),
    .cfg_source_ip(cfg_sip), .cfg_dest_ip(cfg_dip), .cfg_source_port(cfg_sport), .cfg_dest_port(cfg_dport),
    .m_udp_hdr_valid(z_hdr_valid), .m_udp_hdr_ready(z_hdr_ready),
    .m_udp_ip_dscp(z_dscp), .m_udp_ip_ecn(z_ecn), .m_udp_ip_ttl(z_ttl),
    .m_udp_ip_source_ip(z_sip), .m_udp_ip_dest_ip(z_dip),
    .m_udp_source_port(z_sport), .m_udp_dest_port(z_dport),
    .m_udp_length(z_ulen), .m_udp_checksum(z_csum),
    .m_udp_payload_axis_tdata(z_pdata), .m_udp_payload_axis_tvalid(z_pvalid),
    .m_udp_payload_axis_tready(z_pready), .m_udp_payload_axis_tlast(z_plast),
    .m_udp_payload_axis_tuser(z_puser), .datagram_sent(z_sent), .seq_num(z_seq_num)
  );

  int tests = 0;
  int fails = 0;

  // Transaction recorders (append only).
  logic [15:0] hdr_len_q[$], hdr_dport_q[$], z_hdr_len_q[$];
  logic [8:0]  pay_q[$], z_pay_q[$];
  int          sent_cnt = 0, z_sent_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (hdr_valid && hdr_ready) begin
        hdr_len_q.push_back(ulen);
        hdr_dport_q.push_back(dport);
      end
      if (p_tvalid && p_tready) pay_q.push_back({p_tlast, p_tdata});
      if (sent) sent_cnt++;
      if (z_hdr_valid && z_hdr_ready) z_hdr_len_q.push_back(z_ulen);
      if (z_pvalid && z_pready) z_pay_q.push_back({z_plast, z_pdata});
      if (z_sent) z_sent_cnt++;
    end
  end

  // Expected payload stream, {tlast, byte}.
  logic [8:0] exp_q[$];

  task automatic exp_prefix(input logic [31:0] s);
    exp_q.push_back({1'b0, s[31:24]});
    exp_q.push_back({1'b0, s[23:16]});
    exp_q.push_back({1'b0, s[15:8]});
    exp_q.push_back({1'b0, s[7:0]});
  endtask

  task automatic exp_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), 8'(first + 8'(i))});
  endtask

  // Present one byte (starting just after a rising edge) until accepted.
  task automatic send_byte(input bit on0, input logic [7:0] d, input logic l, output bit ok);
    int  n;
    bit  rdy;
    n = 0;
    if (on0) begin z_tdata = d; z_tvalid = 1'b1; z_tlast = l; end
    else     begin s_tdata = d; s_tvalid = 1'b1; s_tlast = l; end
    do begin
      @(negedge clk);
      n++;
      rdy = on0 ? z_tready : s_tready;
    end while (!rdy && n < 500);
    @(posedge clk); #1;
    z_tvalid = 1'b0; z_tlast = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    ok = rdy;
  endtask

  task automatic wait_sent(input bit on0, input int target, output bit ok);
    int n;
    n = 0;
    while ((on0 ? z_sent_cnt : sent_cnt) < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    ok = ((on0 ? z_sent_cnt : sent_cnt) >= target);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({s_tready, hdr_valid, p_tvalid, sent} !== 4'b0000) begin
      fails++; $display("FAIL reset_outputs: got %b want 0000", {s_tready, hdr_valid, p_tvalid, sent});
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    tests++;
    if (seq_num !== 32'd0) begin fails++; $display("FAIL reset_seq: got %h want 0", seq_num); end
    tests++;
    if ({ulen, dport, sport} !== 48'd0 || sip !== 32'd0 || ttl !== 8'd0) begin
      fails++; $display("FAIL reset_hdr: len %h dport %h sport %h sip %h ttl %h want 0", ulen, dport, sport, sip, ttl);
    end
    tests++;
    if (s_tready !== 1'b1 || z_tready !== 1'b1) begin
      fails++; $display("FAIL reset_tready: got %b%b want 11", s_tready, z_tready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream_idle();
    int pb, hb, sb, n;
    bit ok, all_ok;
    logic [8:0] got;
    pb = pay_q.size(); hb = hdr_len_q.size(); sb = sent_cnt;
    all_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_byte(1'b0, 8'(i), 1'b0, ok);
      all_ok &= ok;
    end
    tests++;
    if (!all_ok) begin fails++; $display("FAIL stream_accept: got timeout want all 40 accepted"); end
    // Cycles until the partial datagram's header shows up after the last byte.
    n = 0;
    do begin @(negedge clk); n++; end while (!hdr_valid && n < 200);
    tests++;
    if (n !== IDLE + 1) begin fails++; $display("FAIL idle_flush_delay: got %0d want %0d", n, IDLE + 1); end
    @(posedge clk); #1;
    wait_sent(1'b0, sb + 3, ok);
    tests++;
    if (!ok || sent_cnt - sb !== 3) begin fails++; $display("FAIL stream_sent: got %0d want 3", sent_cnt - sb); end
    tests++;
    if (hdr_len_q.size() - hb !== 3) begin fails++; $display("FAIL stream_hdrs: got %0d want 3", hdr_len_q.size() - hb); end
    else begin
      tests++;
      if ({hdr_len_q[hb], hdr_len_q[hb+1], hdr_len_q[hb+2]} !== {16'd28, 16'd28, 16'd20}) begin
        fails++; $display("FAIL stream_len: got %0d %0d %0d want 28 28 20", hdr_len_q[hb], hdr_len_q[hb+1], hdr_len_q[hb+2]);
      end
    end
    exp_q.delete();
    exp_prefix(32'd0); exp_bytes(8'h00, 16);
    exp_prefix(32'd1); exp_bytes(8'h10, 16);
    exp_prefix(32'd2); exp_bytes(8'h20, 8);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = 'x;
      if (pb + i < pay_q.size()) got = pay_q[pb + i];
      tests++;
      if (got !== exp_q[i]) begin fails++; $display("FAIL stream_pay[%0d]: got %h want %h", i, got, exp_q[i]); end
    end
    tests++;
    if (pay_q.size() - pb !== exp_q.size()) begin fails++; $display("FAIL stream_pay_len: got %0d want %0d", pay_q.size() - pb, exp_q.size()); end
    tests++;
    if (seq_num !== 32'd3) begin fails++; $display("FAIL stream_seq: got %h want 3", seq_num); end
  endtask

  task automatic test_tlast_noseq();
    int pb, hb;
    bit ok, all_ok;
    logic [8:0] got;
    pb = z_pay_q.size(); hb = z_hdr_len_q.size();
    all_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_byte(1'b1, 8'hA1 + 8'(i), (i == 4), ok);
      all_ok &= ok;
    end
    @(negedge clk);
    tests++;
    if ({z_hdr_valid, z_ulen, z_ttl, z_dscp, z_ecn, z_csum} !== {1'b1, 16'd13, 8'd64, 6'd0, 2'd0, 16'd0}) begin
      fails++; $display("FAIL noseq_hdr: valid %b len %0d ttl %0d dscp %0d ecn %0d csum %h want 1 13 64 0 0 0",
                        z_hdr_valid, z_ulen, z_ttl, z_dscp, z_ecn, z_csum);
    end
    tests++;
    if ({z_sip, z_dip, z_sport, z_dport} !== {32'h0A00_0001, 32'h0A00_0002, 16'd4000, 16'd1234}) begin
      fails++; $display("FAIL noseq_addr: got %h %h %0d %0d want 0a000001 0a000002 4000 1234", z_sip, z_dip, z_sport, z_dport);
    end
    @(posedge clk); #1;
    wait_sent(1'b1, z_sent_cnt + 1, ok);
    tests++;
    if (!ok || !all_ok) begin fails++; $display("FAIL noseq_done: got ok=%b/%b want 1/1", ok, all_ok); end
    tests++;
    if (z_hdr_len_q.size() - hb !== 1) begin fails++; $display("FAIL noseq_hdr_count: got %0d want 1", z_hdr_len_q.size() - hb); end
    exp_q.delete();
    exp_bytes(8'hA1, 5);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = 'x;
      if (pb + i < z_pay_q.size()) got = z_pay_q[pb + i];
      tests++;
      if (got !== exp_q[i]) begin fails++; $display("FAIL noseq_pay[%0d]: got %h want %h", i, got, exp_q[i]); end
    end
    tests++;
    if (z_pay_q.size() - pb !== 5) begin fails++; $display("FAIL noseq_pay_len: got %0d want 5", z_pay_q.size() - pb); end
  endtask

  task automatic test_backpressure_cfg();
    int pb, hb, sb;
    bit ok, all_ok, pv, pr;
    logic [7:0] pd;
    logic [8:0] got;
    pb = pay_q.size(); hb = hdr_len_q.size(); sb = sent_cnt;
    hdr_ready = 1'b0;
    all_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_byte(1'b0, 8'hB0 + 8'(i), (i == 5), ok);
      all_ok &= ok;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests++;
      if ({hdr_valid, s_tready, ulen, dport} !== {1'b1, 1'b0, 16'd18, 16'd1234}) begin
        fails++; $display("FAIL hdr_hold[%0d]: valid %b tready %b len %0d dport %0d want 1 0 18 1234",
                          k, hdr_valid, s_tready, ulen, dport);
      end
      @(posedge clk); #1;
      if (k == 3) cfg_dport = 16'd5678;
    end
    hdr_ready = 1'b1;
    p_tready = 1'b0;
    pv = 1'b0; pr = 1'b1; pd = '0;
    for (int k = 0; k < 200 && sent_cnt < sb + 1; k++) begin
      @(negedge clk);
      if (pv && !pr) begin
        tests++;
        if (p_tvalid !== 1'b1 || p_tdata !== pd) begin
          fails++; $display("FAIL stall_stable: got valid %b data %h want 1 %h", p_tvalid, p_tdata, pd);
        end
      end
      pv = p_tvalid; pr = p_tready; pd = p_tdata;
      @(posedge clk); #1;
      p_tready = ~p_tready;
    end
    p_tready = 1'b1;
    tests++;
    if (sent_cnt - sb !== 1 || !all_ok) begin fails++; $display("FAIL stall_sent: got %0d want 1", sent_cnt - sb); end
    tests++;
    if (hdr_dport_q.size() - hb !== 1 || hdr_dport_q[hb] !== 16'd1234) begin
      fails++; $display("FAIL cfg_old_port: got %0d want 1234", (hdr_dport_q.size() > hb) ? hdr_dport_q[hb] : 16'd0);
    end
    exp_q.delete();
    exp_prefix(32'd3); exp_bytes(8'hB0, 6);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = 'x;
      if (pb + i < pay_q.size()) got = pay_q[pb + i];
      tests++;
      if (got !== exp_q[i]) begin fails++; $display("FAIL stall_pay[%0d]: got %h want %h", i, got, exp_q[i]); end
    end
    pb = pay_q.size(); hb = hdr_len_q.size();
    send_byte(1'b0, 8'hE0, 1'b1, ok);
    wait_sent(1'b0, sb + 2, ok);
    tests++;
    if (hdr_dport_q.size() - hb !== 1 || hdr_dport_q[hb] !== 16'd5678 || hdr_len_q[hb] !== 16'd13) begin
      fails++; $display("FAIL cfg_new_port: got %0d len %0d want 5678 13",
                        (hdr_dport_q.size() > hb) ? hdr_dport_q[hb] : 16'd0, (hdr_len_q.size() > hb) ? hdr_len_q[hb] : 16'd0);
    end
    exp_q.delete();
    exp_prefix(32'd4); exp_bytes(8'hE0, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = 'x;
      if (pb + i < pay_q.size()) got = pay_q[pb + i];
      tests++;
      if (got !== exp_q[i]) begin fails++; $display("FAIL cfg_pay[%0d]: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_seq_wrap();
    int pb, sb;
    bit ok;
    logic [8:0] got;
    force dut.seq_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.seq_q;
    @(negedge clk);
    tests++;
    if (seq_num !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_preload: got %h want ffffffff", seq_num); end
    @(posedge clk); #1;
    pb = pay_q.size(); sb = sent_cnt;
    send_byte(1'b0, 8'h11, 1'b0, ok);
    send_byte(1'b0, 8'h12, 1'b1, ok);
    wait_sent(1'b0, sb + 1, ok);
    send_byte(1'b0, 8'h33, 1'b1, ok);
    wait_sent(1'b0, sb + 2, ok);
    exp_q.delete();
    exp_prefix(32'hFFFF_FFFF); exp_bytes(8'h11, 2);
    exp_prefix(32'h0000_0000); exp_bytes(8'h33, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = 'x;
      if (pb + i < pay_q.size()) got = pay_q[pb + i];
      tests++;
      if (got !== exp_q[i]) begin fails++; $display("FAIL wrap_pay[%0d]: got %h want %h", i, got, exp_q[i]); end
    end
    tests++;
    if (seq_num !== 32'd1) begin fails++; $display("FAIL wrap_seq: got %h want 1", seq_num); end
  endtask

  task automatic test_reset_mid_drain();
    int pb, hb, sb, n, pa;
    bit ok;
    logic [8:0] got;
    pb = pay_q.size(); hb = hdr_len_q.size();
    // Byte 16 also carries tlast: exactly one datagram must close.
    for (int i = 0; i < 16; i++) send_byte(1'b0, 8'hD0 + 8'(i), (i == 15), ok);
    n = 0;
    while (pay_q.size() < pb + 12 && n < 200) begin @(posedge clk); #1; n++; end
    tests++;
    if (hdr_len_q.size() - hb !== 1 || hdr_len_q[hb] !== 16'd28) begin
      fails++; $display("FAIL max_tlast_hdr: got %0d hdrs want 1 of len 28", hdr_len_q.size() - hb);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({p_tvalid, hdr_valid, s_tready} !== 3'b001) begin
      fails++; $display("FAIL rst_drain_out: got valid/hdr/tready %b want 001", {p_tvalid, hdr_valid, s_tready});
    end
    tests++;
    if (seq_num !== 32'd0) begin fails++; $display("FAIL rst_drain_seq: got %h want 0", seq_num); end
    hb = hdr_len_q.size(); pa = pay_q.size();
    repeat (30) @(posedge clk);
    #1;
    tests++;
    if (hdr_len_q.size() !== hb || pay_q.size() !== pa) begin
      fails++; $display("FAIL rst_drain_quiet: got %0d hdrs %0d bytes want 0 0", hdr_len_q.size() - hb, pay_q.size() - pa);
    end
    sb = sent_cnt;
    for (int i = 0; i < 3; i++) send_byte(1'b0, 8'hC0 + 8'(i), (i == 2), ok);
    wait_sent(1'b0, sb + 1, ok);
    tests++;
    if (!ok || hdr_len_q.size() - hb !== 1 || hdr_len_q[hb] !== 16'd15) begin
      fails++; $display("FAIL rst_next_hdr: got ok=%b hdrs %0d want 1 of len 15", ok, hdr_len_q.size() - hb);
    end
    exp_q.delete();
    exp_prefix(32'd0); exp_bytes(8'hC0, 3);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = 'x;
      if (pa + i < pay_q.size()) got = pay_q[pa + i];
      tests++;
      if (got !== exp_q[i]) begin fails++; $display("FAIL rst_next_pay[%0d]: got %h want %h", i, got, exp_q[i]); end
    end
    tests++;
    if (pay_q.size() - pa !== 7) begin fails++; $display("FAIL rst_next_len: got %0d want 7", pay_q.size() - pa); end
  endtask

  initial begin
    test_reset();
    test_stream_idle();
    test_tlast_noseq();
    test_backpressure_cfg();
    test_seq_wrap();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/udp_tx_framer.md
Name: udp_tx_framer

Overview:
- Packs a raw 8-bit tape byte stream into UDP datagrams for the UDP stack's UDP-frame input.
- Buffers up to MAX_PAYLOAD bytes, then emits a UDP header with the exact length, optionally a 4-byte sequence number, then the buffered payload.
- Replaces the current tie-off of the TX payload path, which has tvalid forced high and no header generation.
- Sits between the tape data source and the UDP stack's TX UDP port.

Parameters:
MAX_PAYLOAD, 1024, maximum data bytes per datagram (1..1468); buffer depth.
SEQ_ENABLE, 1, 1 = prepend 32-bit big-endian sequence number to each payload.
IDLE_TIMEOUT, 1250, cycles without an accepted byte before a partial datagram is flushed; 0 = never.
IP_TTL, 64, TTL placed in each header.

Ports:
clk  in  1  system clock (125 MHz)
rst  in  1  synchronous active-high reset
s_axis_tdata  in  8  input byte
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  force datagram close after this byte
cfg_source_ip  in  32  local IP
cfg_dest_ip  in  32  destination IP
cfg_source_port  in  16  UDP source port
cfg_dest_port  in  16  UDP destination port
m_udp_hdr_valid  out  1  header valid
m_udp_hdr_ready  in  1  header ready
m_udp_ip_dscp  out  6  constant 0
m_udp_ip_ecn  out  2  constant 0
m_udp_ip_ttl  out  8  IP_TTL
m_udp_ip_source_ip  out  32  latched cfg_source_ip
m_udp_ip_dest_ip  out  32  latched cfg_dest_ip
m_udp_source_port  out  16  latched cfg_source_port
m_udp_dest_port  out  16  latched cfg_dest_port
m_udp_length  out  16  8 + data count + 4*SEQ_ENABLE
m_udp_checksum  out  16  constant 0
m_udp_payload_axis_tdata  out  8  payload byte
m_udp_payload_axis_tvalid  out  1  payload valid
m_udp_payload_axis_tready  in  1  payload ready
m_udp_payload_axis_tlast  out  1  last payload byte
m_udp_payload_axis_tuser  out  1  constant 0
datagram_sent  out  1  one-cycle pulse on final payload handshake
seq_num  out  32  sequence number of the next datagram

Behaviour:
- States: FILL, HDR, SEQ, DRAIN. Reset enters FILL.
- On reset:
  - count = 0, idle counter = 0, seq_num = 0.
  - All valid outputs, s_axis_tready and datagram_sent are 0.
  - Header fields are 0.
- FILL:
  - s_axis_tready = 1.
  - Each accepted byte is written to buffer[count]; count increments; idle counter clears.
  - The datagram closes (go to HDR next cycle, tready drops) when either:
    - the accepted byte makes count == MAX_PAYLOAD, or
    - the accepted byte has tlast = 1.
  - With count > 0 and no byte accepted, the idle counter increments. When it reaches IDLE_TIMEOUT, the datagram closes.
  - With count == 0, the idle counter holds at 0. An empty datagram is never sent.
  - Closing latches all cfg_* inputs and m_udp_length.
  - If the tlast byte is also byte MAX_PAYLOAD, only one datagram closes.
- HDR:
  - m_udp_hdr_valid = 1 and all fields are stable until the handshake.
  - On handshake, go to SEQ if SEQ_ENABLE, else DRAIN.
- SEQ: emit seq_num bytes MSB first, 4 handshakes, then DRAIN. tlast is never asserted here.
- DRAIN:
  - Emit buffer[0..count-1]. tlast is set on byte count-1.
  - tvalid/tdata must not change while tvalid=1 and tready=0.
  - While tready is held high, sustain one byte per cycle with no bubbles, including the SEQ→DRAIN transition. Buffer read latency is hidden by prefetch.
  - On the last handshake:
    - datagram_sent pulses;
    - seq_num increments, wrapping 0xFFFFFFFF→0;
    - count clears;
    - return to FILL.
- cfg_* changes outside the close cycle do not affect an in-flight datagram.
- Reset mid-datagram discards buffered data; no partial output follows.

Decomposition:
- Shared package (udp_framer_pkg):
  - state encoding;
  - UDP_HDR_BYTES = 8;
  - SEQ_BYTES = 4;
  - $clog2-derived count width.
- Sub-module framer_byte_ram: simple dual-port, DEPTH = MAX_PAYLOAD, 8-bit, 1-cycle registered read, infers block RAM.

Test Plan:
- MAX_PAYLOAD=16, SEQ_ENABLE=1, 40 bytes 0x00..0x27 with no tlast, sink always ready → datagrams of 16, 16 and 8 bytes. The last one flushes IDLE_TIMEOUT cycles after byte 0x27. m_udp_length = 28, 28, 20. Sequence prefixes are 0, 1, 2. datagram_sent pulses 3 times.
- 5 bytes 0xA1..0xA5 with tlast on 0xA5, SEQ_ENABLE=0 → one header, length 13. Payload A1..A5 with tlast on A5 only.
- Sink tready toggles 1/0 every cycle during DRAIN → payload order intact and tdata stable while stalled. Header hdr_ready held low 10 cycles → s_axis_tready stays 0 and fields stay stable.
- Preload seq_num to 0xFFFFFFFF via 2^32-1 datagrams, or force it in simulation → prefix FF FF FF FF, then the next prefix is 00 00 00 00.
- Assert rst for 1 cycle during DRAIN of a 16-byte datagram → tvalid is 0 the next cycle, seq_num = 0, s_axis_tready = 1, and no stale bytes appear in the next datagram.
- Change cfg_dest_port from 1234 to 5678 while in HDR → the current header keeps 1234 and the next datagram carries 5678.
